// File: rtl/bch_syndrome.sv
// bch_syndrome: streaming BCH syndrome generator for the HQC decoder chain.
// Absorbs codeword bits MSB first with a Horner update S_i <- S_i*alpha^i ^ r
// for i = 1..2*PARAM_DELTA over GF(2^PARAM_M), and returns one syndrome per
// READ command through the common enable/in_1/in_2/out_1/ready interface.
// Optional build macro: SYNDROME_ZERO_FLAG_EN adds an all-zero detector that
// READ index 8'hFF reports as {31'b0, all_zero}.
module bch_syndrome #(
   parameter int                 PARAM_M     = 9,
   parameter int                 PARAM_DELTA = 4,
   parameter logic [PARAM_M:0]   PARAM_POLY  = 10'h211
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] in_1,
   input  logic [31:0] in_2,
   output logic [31:0] out_1,
   output logic        ready
);

   localparam int NSYN = 2 * PARAM_DELTA;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [1:0] OP_CLEAR  = 2'b00;
   localparam logic [1:0] OP_ABSORB = 2'b01;
   localparam logic [1:0] OP_READ   = 2'b10;

   // Multiply by x modulo the field polynomial.
   function automatic logic [PARAM_M-1:0] xtime(input logic [PARAM_M-1:0] a);
      logic [PARAM_M-1:0] r;
      r = a << 1;
      if (a[PARAM_M-1]) r = r ^ PARAM_POLY[PARAM_M-1:0];
      return r;
   endfunction

   // x^e reduced modulo the field polynomial; evaluated at elaboration.
   function automatic logic [PARAM_M-1:0] alpha_pow(input int e);
      logic [PARAM_M-1:0] p;
      p = {{(PARAM_M-1){1'b0}}, 1'b1};
      for (int j = 0; j < e; j++) p = xtime(p);
      return p;
   endfunction

   // GF(2^M) product; with a constant operand this folds into an XOR network.
   function automatic logic [PARAM_M-1:0] gf_mul(input logic [PARAM_M-1:0] a,
                                                 input logic [PARAM_M-1:0] c);
      logic [PARAM_M-1:0] acc;
      acc = '0;
      for (int j = PARAM_M - 1; j >= 0; j--) begin
         acc = xtime(acc);
         if (a[j]) acc = acc ^ c;
      end
      return acc;
   endfunction

   state_t             state, state_nx;
   logic               enable_q;
   logic               fire;
   logic [1:0]         opcode;
   logic [31:0]        shreg;
   logic [5:0]         cnt;
   logic [PARAM_M-1:0] syn      [1:NSYN];
   logic [PARAM_M-1:0] syn_step [1:NSYN];
   logic [31:0]        rd_val;
   logic               unused_in_1;

   assign opcode      = in_1[31:30];
   assign fire        = enable & ~enable_q & (state == IDLE);
   assign ready       = (state == DONE);
   assign unused_in_1 = ^in_1[29:8];

   // One Horner step per syndrome: multiply by its alpha^i, add the current bit.
   for (genvar i = 1; i <= NSYN; i++) begin : g_step
      localparam logic [PARAM_M-1:0] ALPHA_I = alpha_pow(i);
      assign syn_step[i] = gf_mul(syn[i], ALPHA_I) ^ {{(PARAM_M-1){1'b0}}, shreg[31]};
   end

   // READ result mux: in-range index selects a syndrome, anything else is zero.
   always_comb begin
      rd_val = '0;
      for (int k = 1; k <= NSYN; k++) begin
         if (in_1[7:0] == 8'(k)) rd_val = {{(32-PARAM_M){1'b0}}, syn[k]};
      end
`ifdef SYNDROME_ZERO_FLAG_EN
      if (in_1[7:0] == 8'hFF) begin
         rd_val = 32'd1;
         for (int k = 1; k <= NSYN; k++) begin
            if (syn[k] != '0) rd_val = 32'd0;
         end
      end
`endif
   end

   // State register and enable edge detector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         enable_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state    <= state_nx;
         enable_q <= enable;
      end
   end

   // Next-state logic: ABSORB waits in BUSY for its bits, all else goes straight to DONE.
   always_comb begin
      // NOTE: default assigned first so no path through the case infers a latch.
      state_nx = state;
      case (state)
         IDLE: if (fire) state_nx = (opcode == OP_ABSORB) ? BUSY : DONE;
         BUSY: if (cnt == 6'd1) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: command execution, bit streaming and the READ output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the syndrome array is reset element-wise because reset must clear all syndromes; a large RAM would not be.
         for (int k = 1; k <= NSYN; k++) syn[k] <= '0;
         shreg <= '0;
         cnt   <= '0;
         out_1 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fire) begin
                  case (opcode)
                     OP_CLEAR: for (int k = 1; k <= NSYN; k++) syn[k] <= '0;
                     OP_ABSORB: begin
                        shreg <= in_2;
                        cnt   <= (in_1[5:0] == 6'd0) ? 6'd32 : in_1[5:0];
                     end
                     OP_READ: out_1 <= rd_val;
                     default: ;
                  endcase
               end
            end
            BUSY: begin
               for (int k = 1; k <= NSYN; k++) syn[k] <= syn_step[k];
               shreg <= shreg << 1;
               cnt   <= cnt - 6'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bch_syndrome.sv
// Directed testbench for bch_syndrome: CLEAR/ABSORB/READ sequences with
// hand-computed GF(2^9) syndrome values, latency and pulse checks, enable
// hold and re-trigger behaviour, and asynchronous reset mid-ABSORB.
module tb_bch_syndrome;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [31:0] in_1;
   logic [31:0] in_2;
   logic [31:0] out_1;
   logic        ready;

   int n_checks = 0;
   int n_pass   = 0;

   bch_syndrome dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .in_1   (in_1),
      .in_2   (in_2),
      .out_1  (out_1),
      .ready  (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] w_clear();
      return 32'h0000_0000;
   endfunction

   function automatic logic [31:0] w_absorb(input int n);
      return {2'b01, 24'b0, 6'(n)};
   endfunction

   function automatic logic [31:0] w_read(input int idx);
      return {2'b10, 22'b0, 8'(idx)};
   endfunction

   // Issue one command: raise enable after a falling edge, keep it high for
   // 'hold' rising edges, observe ready for 'window' edges (sampled 1 ns after).
   task automatic command(input logic [31:0] w1, input logic [31:0] w2,
                          input int hold, input int window,
                          output int lat, output int pulses, output logic [31:0] val);
      lat    = 0;
      pulses = 0;
      val    = 'x;
      @(negedge clk);
      in_1   = w1;
      in_2   = w2;
      enable = 1'b1;
      for (int c = 1; c <= window; c++) begin
         @(posedge clk);
         #1;
         if (ready) begin
            pulses++;
            if (lat == 0) begin
               lat = c;
               val = out_1;
            end
         end
         if (c == hold) enable = 1'b0;
      end
      enable = 1'b0;
   endtask

   task automatic do_read(input int idx, input logic [31:0] exp, input string tag);
      int lat, pulses;
      logic [31:0] val;
      command(w_read(idx), 32'h0, 1, 4, lat, pulses, val);
      check({tag, "_pulses"}, 32'(pulses), 32'd1);
      check(tag, val, exp);
   endtask

   // Safety net: never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, pulses, late_pulses;
      logic [31:0] val;
      logic [31:0] exp_two_zero [1:8];

      exp_two_zero = '{32'h004, 32'h010, 32'h040, 32'h100,
                       32'h022, 32'h088, 32'h031, 32'h0C4};

      rst    = 1'b0;
      enable = 1'b0;
      in_1   = '0;
      in_2   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_1", out_1, 32'h0);
      check("reset_ready", {31'b0, ready}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // CLEAR then READ every index: all zero.
      command(w_clear(), 32'h0, 1, 4, lat, pulses, val);
      check("clear_pulses", 32'(pulses), 32'd1);
      check("clear_latency_ok", {31'b0, (lat >= 1 && lat <= 2)}, 32'd1);
      for (int k = 1; k <= 8; k++) do_read(k, 32'h0, $sformatf("zero_read%0d", k));

      // Single 1 bit (lower in_2 bits must be ignored): every S_i = 1.
      command(w_clear(), 32'h0, 1, 4, lat, pulses, val);
      command(w_absorb(1), 32'h8000_0001, 1, 6, lat, pulses, val);
      check("absorb1_latency", 32'(lat), 32'd2);
      check("absorb1_pulses", 32'(pulses), 32'd1);
      for (int k = 1; k <= 8; k++) do_read(k, 32'h001, $sformatf("one_read%0d", k));

      // Two more zero bits: S_i = alpha^(2i); out_1 untouched by ABSORB.
      command(w_absorb(2), 32'h0000_0000, 1, 6, lat, pulses, val);
      check("absorb2_latency", 32'(lat), 32'd3);
      check("absorb_keeps_out_1", out_1, 32'h001);
      for (int k = 1; k <= 8; k++) do_read(k, exp_two_zero[k], $sformatf("a2i_read%0d", k));
      do_read(0, 32'h0, "read_idx0");
      do_read(9, 32'h0, "read_idx9");
      do_read(8'hFF, 32'h0, "read_ff_nonzero");

      // CLEAR resets syndromes and leaves out_1 alone.
      command(w_clear(), 32'h0, 1, 4, lat, pulses, val);
      check("clear_keeps_out_1", out_1, 32'h0);
      command(w_absorb(2), 32'hC000_0000, 1, 6, lat, pulses, val);
      do_read(1, 32'h003, "bits11_read1");
      do_read(2, 32'h005, "bits11_read2");
      do_read(3, 32'h009, "bits11_read3");

      // n=0 means 32 bits; a second rising edge during BUSY is ignored.
      command(w_clear(), 32'h0, 1, 4, lat, pulses, val);
      @(negedge clk);
      in_1   = w_absorb(0);
      in_2   = 32'h0;
      enable = 1'b1;
      lat    = 0;
      pulses = 0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk);
         #1;
         if (ready) begin
            pulses++;
            if (lat == 0) lat = c;
         end
         if (c == 2) enable = 1'b0;
         if (c == 5) begin
            in_1   = w_absorb(1);
            in_2   = 32'h8000_0000;
            enable = 1'b1;
         end
         if (c == 7) enable = 1'b0;
      end
      check("absorb32_latency", 32'(lat), 32'd33);
      check("absorb32_pulses", 32'(pulses), 32'd1);
      for (int k = 1; k <= 8; k++) do_read(k, 32'h0, $sformatf("z32_read%0d", k));
`ifdef SYNDROME_ZERO_FLAG_EN
      do_read(8'hFF, 32'h1, "read_ff_allzero");
`else
      do_read(8'hFF, 32'h0, "read_ff_allzero");
`endif

      // Enable held for 6 cycles: exactly one command executes.
      command(w_absorb(1), 32'h8000_0000, 6, 12, lat, pulses, val);
      check("hold_latency", 32'(lat), 32'd2);
      check("hold_pulses", 32'(pulses), 32'd1);
      do_read(1, 32'h001, "hold_read1");
      do_read(8, 32'h001, "hold_read8");

      // Reset 10 cycles into a 32-bit ABSORB: aborted, no ready, state cleared.
      command(w_absorb(0), 32'hFFFF_FFFF, 1, 10, lat, pulses, val);
      check("pre_reset_no_ready", 32'(pulses), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("in_reset_out_1", out_1, 32'h0);
      check("in_reset_ready", {31'b0, ready}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      late_pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (ready) late_pulses++;
      end
      check("post_reset_no_ready", 32'(late_pulses), 32'd0);
      do_read(1, 32'h0, "post_reset_read1");
      do_read(4, 32'h0, "post_reset_read4");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
